// File: rtl/hack_cpu_core.sv
// ---------------------------------------------------------------------------
// hack_cpu_core
//   Fetch-free Hack CPU core. It decodes each 16-bit instruction and evaluates
//   the Hack ALU on it. It holds the A, D and PC registers and drives the data
//   RAM interface. One instruction retires per unstalled clock.
//
// Ports
//   clk          in   1   system clock, rising-edge state updates
//   reset        in   1   synchronous active-high; clears A, D, loads PC_RESET
//   stall        in   1   hold all state and suppress the memory write
//   instruction  in  16   instruction word at ROM[pc]
//   inM          in  16   RAM[addressM] read data
//   outM         out 16   ALU result (combinational), RAM write data
//   writeM       out  1   RAM write enable for this cycle (combinational)
//   addressM     out 15   A[14:0] (registered)
//   pc           out 15   address of the current instruction (registered)
// ---------------------------------------------------------------------------
module hack_cpu_core #(
    parameter logic [14:0] PC_RESET = 15'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);

    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;

    logic               is_c;
    logic               sel_m;
    logic        [15:0] alu_y;
    logic signed [15:0] alu_out;
    logic               zr;
    logic               ng;
    logic               take;
    logic [14:0]        pc_inc;

    // Hack ALU: x/y optionally zeroed then inverted, add or AND, then the
    // result is optionally inverted. The add wraps at 16 bits.
    function automatic logic signed [15:0] hack_alu(
        input logic [15:0] x_in,
        input logic [15:0] y_in,
        input logic [5:0]  ctl
    );
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        x = ctl[5] ? 16'h0000 : x_in;
        x = ctl[4] ? ~x : x;
        y = ctl[3] ? 16'h0000 : y_in;
        y = ctl[2] ? ~y : y;
        r = ctl[1] ? (x + y) : (x & y);
        r = ctl[0] ? ~r : r;
        return $signed(r);
    endfunction

    // ---- decode / execute (combinational, zero-cycle latency) ----
    always_comb begin
        is_c    = instruction[15];
        sel_m   = instruction[12];
        alu_y   = sel_m ? inM : a_q;
        alu_out = hack_alu(d_q, alu_y, instruction[11:6]);
        zr      = (alu_out == 16'sd0);
        ng      = (alu_out < 16'sd0);
        take    = (instruction[2] & ng) |
                  (instruction[1] & zr) |
                  (instruction[0] & ~ng & ~zr);
        pc_inc  = pc_q + 15'd1;

        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;
        if (!stall) begin
            if (!is_c) begin
                a_d  = {1'b0, instruction[14:0]};
                pc_d = pc_inc;
            end else begin
                if (instruction[5]) a_d = alu_out;
                if (instruction[4]) d_d = alu_out;
                // Jump target is the A value before this instruction's write.
                pc_d = take ? a_q[14:0] : pc_inc;
            end
        end
    end

    assign outM     = alu_out;
    assign writeM   = is_c & instruction[3] & ~stall & ~reset;
    assign addressM = a_q[14:0];
    assign pc       = pc_q;

    // ---- architectural register update ----
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            pc_q <= PC_RESET;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

endmodule
